// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: segment bit positions,
// blank pattern, common polarity and the scan phase type.
package seg_pkg;

    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Commons are active-low, so "off" is a one.
    localparam logic COM_OFF = 1'b1;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } scan_phase_t;

endpackage

// File: rtl/seg_decode.sv
// Hex nibble to seven-segment pattern, active-high, bit7=a .. bit1=g.
// The dp position is always returned as 0; the caller merges its own dp.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] value,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (value)
            4'h0: seg = 8'hFC;
            4'h1: seg = 8'h60;
            4'h2: seg = 8'hDA;
            4'h3: seg = 8'hF2;
            4'h4: seg = 8'h66;
            4'h5: seg = 8'hB6;
            4'h6: seg = 8'hBE;
            4'h7: seg = 8'hE0;
            4'h8: seg = 8'hFE;
            4'h9: seg = 8'hF6;
            4'hA: seg = 8'hEE;
            4'hB: seg = 8'h3E;
            4'hC: seg = 8'h9C;
            4'hD: seg = 8'h7A;
            4'hE: seg = 8'h9E;
            4'hF: seg = 8'h8E;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner: digit register file, slot prescaler,
// blank/drive phase machine, leading-zero suppression and registered pin drive.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [3:0]        wr_data,
    input  logic              wr_dp,
    input  logic [DIGITS-1:0] digit_en,
    input  logic              lz_en,
    output logic [7:0]        seg_out,
    output logic [DIGITS-1:0] com_out,
    output logic              frame_tick
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(DIGITS);
    localparam scan_phase_t PHASE_RST = (BLANK_CYCLES > 0) ? PH_BLANK : PH_DRIVE;

    logic [3:0]       val_q [DIGITS];
    logic             dp_q  [DIGITS];

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             wrap_q, wrap_d;
    scan_phase_t      phase_q, phase_d;

    logic [DIGITS-1:0] supp;
    logic              any_nz;
    logic [3:0]        cur_val;
    logic              cur_dp;
    logic              cur_en;
    logic              cur_supp;
    logic [7:0]        dec_seg;
    logic              lit;
    logic [7:0]        seg_d;
    logic [DIGITS-1:0] com_d;

    // Out-of-range addresses match no entry and are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) begin
                val_q[i] <= 4'h0;
                dp_q[i]  <= 1'b0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (wr_addr == 3'(i)) begin
                    val_q[i] <= wr_data;
                    dp_q[i]  <= wr_dp;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q   <= '0;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
            phase_q <= PHASE_RST;
        end else begin
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            phase_q <= phase_d;
        end
    end

    // wrap_q marks the (idx=0, pre=0) state reached by a wrap, not by reset.
    always_comb begin
        pre_d  = pre_q + PRE_W'(1);
        idx_d  = idx_q;
        wrap_d = 1'b0;
        if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            pre_d = '0;
            if (idx_q == IDX_W'(DIGITS - 1)) begin
                idx_d  = '0;
                wrap_d = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
        phase_d = (int'(pre_d) < BLANK_CYCLES) ? PH_BLANK : PH_DRIVE;
    end

    // Walk from the top digit down; a digit is suppressible while nothing
    // at or above it carries a non-zero value or a dp.
    always_comb begin
        any_nz = 1'b0;
        supp   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            any_nz  = any_nz | (val_q[i] != 4'h0) | dp_q[i];
            supp[i] = lz_en && (i != 0) && !any_nz;
        end
    end

    always_comb begin
        cur_val  = 4'h0;
        cur_dp   = 1'b0;
        cur_en   = 1'b0;
        cur_supp = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_val  = val_q[i];
                cur_dp   = dp_q[i];
                cur_en   = digit_en[i];
                cur_supp = supp[i];
            end
        end
    end

    seg_decode u_dec (
        .value (cur_val),
        .seg   (dec_seg)
    );

    always_comb begin
        lit   = (phase_q == PH_DRIVE) && cur_en && !cur_supp;
        seg_d = SEG_BLANK;
        com_d = {DIGITS{COM_OFF}};
        if (lit) begin
            seg_d         = dec_seg;
            seg_d[SEG_DP] = cur_dp;
            com_d         = ~(DIGITS'(1) << idx_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_out    <= SEG_BLANK;
            com_out    <= {DIGITS{COM_OFF}};
            frame_tick <= 1'b0;
        end else begin
            seg_out    <= seg_d;
            com_out    <= com_d;
            frame_tick <= wrap_q;
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Multiplexed seven-segment display scanner. Holds one hex nibble and one decimal-point bit per digit, time-multiplexes the shared segment bus across `DIGITS` common lines at a programmable rate, and inserts a blanking gap at each digit change to prevent ghosting. Optional leading-zero suppression is supported. It sits between the system logic that writes digit values and the board's segment/common pins. It drives the shared hex-to-segment decoder `seg_decode`.

## Interface
- `DIGITS`, 8: number of multiplexed digits, legal range 2..8.
- `SCAN_DIV`, 1000: clocks per digit slot, must be at least 2.
- `BLANK_CYCLES`, 2: clocks at the start of each slot with all commons off; legal range is 0 up to `SCAN_DIV`-1.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  write strobe for the digit register file.
- `wr_addr`  in  3  digit index to write; values at or above `DIGITS` are ignored.
- `wr_data`  in  4  hex value to store.
- `wr_dp`  in  1  decimal-point bit to store.
- `digit_en`  in  DIGITS  per-digit display enable; bit i gates digit i; static level.
- `lz_en`  in  1  leading-zero suppression enable.
- `seg_out`  out  8  segment drive, active-high; bit7=a … bit1=g, bit0=dp.
- `com_out`  out  DIGITS  digit commons, active-low; bit i is digit i.
- `frame_tick`  out  1  one-clock pulse when the scan wraps from digit `DIGITS`-1 back to digit 0.

## Operation
- Register file holds `DIGITS`×{4-bit value, dp}.
  - Cleared to 0 on reset.
  - On a clock edge with `wr_en`=1 and `wr_addr`<`DIGITS`, entry `wr_addr` is updated.
- Prescaler `pre` counts 0..`SCAN_DIV`-1 and wraps to 0.
  - When `pre`=`SCAN_DIV`-1, digit index `idx` advances.
  - `idx` wraps from `DIGITS`-1 to 0.
- Scan phase machine, per slot:
  - BLANK while `pre`<`BLANK_CYCLES`.
  - DRIVE for the rest of the slot.
  - BLANK is skipped when `BLANK_CYCLES`=0.
- Leading-zero suppression, when `lz_en`=1: digit i>0 is suppressed if every digit j≥i has value 0 and dp 0. Digit 0 is never suppressed.
- Output next-state:
  - In BLANK, or when `digit_en[idx]`=0, or when digit `idx` is suppressed: `com_out` is all ones and `seg_out`=8'h00.
  - In DRIVE: `com_out`=~(1<<idx). `seg_out` is the decoder output for `value[idx]`, with bit0 replaced by `dp[idx]`.
- Decoder encoding for 0–F: FC, 60, DA, F2, 66, B6, BE, E0, FE, F6, EE, 3E, 9C, 7A, 9E, 8E (bit0 is 0 in all codes).
- `frame_tick` is asserted for exactly the one clock in which the `idx` wrap takes effect on the outputs.

## Timing
- Reset values:
  - `seg_out`=8'h00, `com_out`=all ones, `frame_tick`=0.
  - `pre`=0, `idx`=0, register file all 0.
  - All of these take effect immediately on `rst` assertion, independent of `clk`.
- `seg_out`, `com_out` and `frame_tick` are registered. They lag the `pre`/`idx` state by one clock.
- Write latency: a write accepted at edge E appears on `seg_out` at edge E+1 if digit `wr_addr` is currently in DRIVE.
- A write during the active slot of that same digit changes the segments mid-slot. This is allowed and produces no glitch beyond the single register update.
- A write to address ≥`DIGITS` changes no state.
- Reset asserted mid-slot discards the slot. After release, scanning restarts at digit 0 with `pre`=0, i.e. in BLANK.
- Frame period is `DIGITS`×`SCAN_DIV` clocks, exactly.
- `lz_en` and `digit_en` are sampled every clock. A change takes effect one clock later on the outputs.

## Structure
- Shared package `seg_pkg` holds:
  - segment bit-position constants A..G and DP;
  - `SEG_BLANK`=8'h00;
  - the common polarity constant `COM_OFF`=1.
- Sub-module: existing `seg_decode`, 4-bit to 8-bit, instantiated once on the muxed `value[idx]`.
- All other logic stays in this module: register file, prescaler, `idx`, LZ logic and output registers.

## Test plan
All tests use `DIGITS`=4, `SCAN_DIV`=8, `BLANK_CYCLES`=2.
- Reset: hold `rst`=1, then release → `seg_out`=00, `com_out`=4'b1111, `frame_tick`=0. The first lit digit 0 appears 3 clocks after release, if enabled.
- Basic scan: write 1,2,3,4 to digits 0..3; `digit_en`=4'hF; `lz_en`=0 → each 8-clock slot shows 2 clocks of 1111/00, then 6 clocks of:
  - 1110/60 for digit 0;
  - 1101/DA for digit 1;
  - 1011/F2 for digit 2;
  - 0111/66 for digit 3.
- Leading zeros: values {3:0,2:0,1:0,0:5}, `lz_en`=1 → only digit 0 lit (1110/B6); digits 1–3 stay 1111/00. With `lz_en`=0, digits 1–3 show FC.
- DP and disable: write digit 2 = 8 with `wr_dp`=1 → slot 2 shows 1011/FF. Then set `digit_en[2]`=0 → slot 2 shows 1111/00.
- Wrap and frame: `frame_tick` pulses exactly once per 32 clocks, coincident with the first output cycle of digit 0's slot. A write with `wr_addr`=5 changes nothing.
- Mid-slot reset: assert `rst` in a DRIVE cycle of digit 2 → outputs return to 00/1111 asynchronously. After release, all digits read value 0 and scanning restarts at digit 0.
